// File: rtl/pipe_pkg.sv
// Shared definitions for the valid/ready pipeline register with skid entry:
// state encoding, stall counter width and an occupancy helper.
package pipe_pkg;

    localparam int STALL_CNT_W = 32;

    // 2'b11 is unused; the register recovers from it to EMPTY.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b10
    } pipeStateT;

    function automatic logic [1:0] stateCount(input pipeStateT s);
        case (s)
            ONE:     return 2'd1;
            FULL:    return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_stall_counter.sv
// Saturating event counter used to count downstream backpressure cycles.
module pipe_stall_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_reg_skid.sv
// Generic inter-stage register: main entry plus one skid entry, registered in_ready.
// Optional backpressure counter enabled with `define PIPE_STALL_CNT_EN.
// Handshake: a beat moves when valid && ready are both high at a rising clk edge;
// upstream holds in_data while in_valid && !in_ready, and may drop in_valid at will.
module pipe_reg_skid
    import pipe_pkg::*;
#(
    parameter int                DATA_W  = 32,
    parameter logic [DATA_W-1:0] RST_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        count
`ifdef PIPE_STALL_CNT_EN
    ,
    output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);

    pipeStateT         stateQ, stateNext;
    logic              inReadyQ;
    logic [DATA_W-1:0] mainData, skidData;
    logic              xferIn, xferOut;
    logic              loadMainIn, loadMainSkid, loadSkid;

    assign out_valid = (stateQ == ONE) || (stateQ == FULL);
    assign in_ready  = inReadyQ;
    assign out_data  = mainData;
    assign count     = stateCount(stateQ);
    assign xferIn    = in_valid && inReadyQ;
    assign xferOut   = out_valid && out_ready;

    // flush beats every transfer in the same cycle; payloads are left untouched.
    always_comb begin
        stateNext    = stateQ;
        loadMainIn   = 1'b0;
        loadMainSkid = 1'b0;
        loadSkid     = 1'b0;
        if (flush) begin
            stateNext = EMPTY;
        end else begin
            case (stateQ)
                EMPTY: begin
                    if (xferIn) begin
                        loadMainIn = 1'b1;
                        stateNext  = ONE;
                    end
                end
                ONE: begin
                    if (xferIn && xferOut) begin
                        loadMainIn = 1'b1;
                    end else if (xferIn) begin
                        loadSkid  = 1'b1;
                        stateNext = FULL;
                    end else if (xferOut) begin
                        stateNext = EMPTY;
                    end
                end
                FULL: begin
                    if (xferOut) begin
                        loadMainSkid = 1'b1;
                        stateNext    = ONE;
                    end
                end
                default: stateNext = EMPTY;
            endcase
        end
    end

    // in_ready is derived from the next state so it never depends on out_ready combinationally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stateQ   <= EMPTY;
            inReadyQ <= 1'b1;
        end else begin
            stateQ   <= stateNext;
            inReadyQ <= (stateNext != FULL);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mainData <= RST_VAL;
            skidData <= RST_VAL;
        end else begin
            if (loadMainIn) begin
                mainData <= in_data;
            end else if (loadMainSkid) begin
                mainData <= skidData;
            end
            if (loadSkid) begin
                skidData <= in_data;
            end
        end
    end

`ifdef PIPE_STALL_CNT_EN
    pipe_stall_counter #(
        .W(STALL_CNT_W)
    ) u_stall_counter (
        .clk(clk),
        .rst(rst),
        .inc(out_valid && !out_ready),
        .cnt(stall_cnt)
    );
`endif

endmodule

// File: tb/tb_pipe_reg_skid.sv
// Bench for pipe_reg_skid: directed and random traffic against a queue-based model.
module tb_pipe_reg_skid;

    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              flush = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        count;
`ifdef PIPE_STALL_CNT_EN
    logic [31:0]       stall_cnt;
`endif

    int  checks = 0;
    int  errors = 0;
    bit  monEn = 1'b0;
    bit  inTook = 1'b0;
    logic [DATA_W-1:0] exp_q[$];
    logic [31:0]       stallExp = '0;

    pipe_reg_skid #(.DATA_W(DATA_W), .RST_VAL('0)) dut (
        .clk(clk),
        .rst(rst),
        .flush(flush),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .count(count)
`ifdef PIPE_STALL_CNT_EN
        ,
        .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Driver: apply one cycle of inputs just after a rising edge.
    task automatic drive(input logic v, input logic [DATA_W-1:0] d, input logic r, input logic f);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
        @(posedge clk);
        #1;
    endtask

    // Monitor/scoreboard: the model is simply the ordered list of beats held.
    always @(negedge clk) begin
        if (monEn) begin
            automatic int n = exp_q.size();
            automatic logic [DATA_W-1:0] e;
            chk("out_valid", 32'(out_valid), 32'(n > 0));
            chk("in_ready", 32'(in_ready), 32'(n < 2));
            chk("count", 32'(count), 32'(n));
`ifdef PIPE_STALL_CNT_EN
            chk("stall_cnt", stall_cnt, stallExp);
`endif
            inTook = 1'b0;
            if (flush) begin
                exp_q.delete();
                inTook = in_valid;
            end else begin
                if (n > 0 && out_ready) begin
                    e = exp_q.pop_front();
                    chk("out_data", 32'(out_data), 32'(e));
                end
                if (in_valid && n < 2) begin
                    exp_q.push_back(in_data);
                    inTook = 1'b1;
                end
            end
            if (n > 0 && !out_ready && stallExp != 32'hFFFF_FFFF) stallExp++;
        end
    end

    task automatic async_reset_check();
        @(posedge clk);
        #3;
        monEn = 1'b0;
        rst   = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_count", 32'(count), 32'd0);
`ifdef PIPE_STALL_CNT_EN
        chk("rst_stall_cnt", stall_cnt, 32'd0);
`endif
        exp_q.delete();
        stallExp  = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
        @(posedge clk);
        #1;
        rst   = 1'b1;
        monEn = 1'b1;
    endtask

    initial begin
        logic [DATA_W-1:0] curData;
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("init_out_valid", 32'(out_valid), 32'd0);
        chk("init_in_ready", 32'(in_ready), 32'd1);
        chk("init_count", 32'(count), 32'd0);
        rst   = 1'b1;
        monEn = 1'b1;

        // Back-to-back stream with downstream always ready
        for (int i = 1; i <= 8; i++) drive(1'b1, DATA_W'(i), 1'b1, 1'b0);
        repeat (3) drive(1'b0, '0, 1'b1, 1'b0);

        // Backpressure: fill both entries, hold the third beat, then drain
        drive(1'b1, 32'hA, 1'b0, 1'b0);
        drive(1'b1, 32'hB, 1'b0, 1'b0);
        drive(1'b1, 32'hC, 1'b0, 1'b0);
        drive(1'b1, 32'hC, 1'b0, 1'b0);
        drive(1'b1, 32'hC, 1'b1, 1'b0);
        drive(1'b1, 32'hC, 1'b1, 1'b0);
        repeat (4) drive(1'b0, '0, 1'b1, 1'b0);

        // Simultaneous in/out while holding one beat
        drive(1'b1, 32'h5, 1'b0, 1'b0);
        drive(1'b1, 32'h6, 1'b1, 1'b0);
        repeat (2) drive(1'b0, '0, 1'b1, 1'b0);

        // Flush while full, with a beat offered in the same cycle
        drive(1'b1, 32'h11, 1'b0, 1'b0);
        drive(1'b1, 32'h22, 1'b0, 1'b0);
        drive(1'b1, 32'h33, 1'b1, 1'b1);
        repeat (3) drive(1'b0, '0, 1'b1, 1'b0);

        // Async reset while full
        drive(1'b1, 32'h44, 1'b0, 1'b0);
        drive(1'b1, 32'h55, 1'b0, 1'b0);
        async_reset_check();
        repeat (2) drive(1'b0, '0, 1'b1, 1'b0);

        // Stall counting over a fixed window, then flush
        drive(1'b1, 32'h77, 1'b0, 1'b0);
        repeat (10) drive(1'b0, '0, 1'b0, 1'b0);
`ifdef PIPE_STALL_CNT_EN
        chk("stall_ten", stall_cnt, 32'd10);
`endif
        drive(1'b0, '0, 1'b0, 1'b1);
        drive(1'b0, '0, 1'b1, 1'b0);
`ifdef PIPE_STALL_CNT_EN
        chk("stall_after_flush", stall_cnt, 32'd11);
`endif

        // Random traffic; in_data only changes once the offered beat was taken
        curData = DATA_W'($urandom);
        for (int c = 0; c < 3000; c++) begin
            if (inTook) curData = DATA_W'($urandom);
            drive(1'($urandom_range(0, 9) < 7), curData,
                  1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 31) == 0));
        end
        repeat (4) drive(1'b0, '0, 1'b1, 1'b0);
        chk("final_drained", 32'(exp_q.size()), 32'd0);

        monEn = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
